game_state_controller: RTL and testbench
========================================

Name: game_state_controller

Overview:
- Top-level game sequencer for the hole-in-the-wall pipeline.
- Owns game state, wall depth, wall selection, lives and score.
- Feeds game_state and wall_depth to the graphics controller and wall renderer, and consumes the per-pixel collision flag produced upstream.
- Advances once per video frame, using the hcount/vcount raster as its timebase.

Parameters:
- ACTIVE_H_PIXELS, 1280, active pixels per line
- ACTIVE_LINES, 720, active lines per frame
- MAX_WALL_DEPTH, 75, spawn depth of a new wall
- GOAL_DEPTH_DELTA, 10, half-width of the collision window around player depth
- FRAMES_PER_STEP, 2, frame ticks per one-unit wall depth decrement (>=1)
- COLLISION_THRESHOLD, 64, collision pixels in one frame that count as a hit
- RESULT_FRAMES, 90, frames the RESULT state is held
- NUM_LIVES, 3, lives at game start (1..3)
- NUM_WALLS, 8, wall patterns cycled through (1..16)

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  asynchronous, active-low reset (0 = reset)
- hcount_in  input  11  raster x
- vcount_in  input  10  raster y
- start_in  input  1  start button, synchronised upstream, level
- is_collision_in  input  1  current pixel is a collision
- player_depth_in  input  8  player depth estimate
- game_state_out  output  3  0=GAME_OVER, 1=IDLE, 2=APPROACH, 3=RESULT
- wall_depth_out  output  8  current wall depth
- wall_index_out  output  4  active wall pattern
- lives_out  output  2  remaining lives
- score_out  output  8  walls passed, saturating at 255
- last_pass_out  output  1  1 = last wall passed, 0 = hit

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, wall_depth=MAX_WALL_DEPTH, wall_index=0, lives=NUM_LIVES, score=0, last_pass=0.
  - Frame, step and collision counters=0; start edge register=0.
- frame_tick: single-cycle pulse on the first cycle where (hcount_in==0 && vcount_in==ACTIVE_LINES), detected by edge of the registered condition.
  - All state transitions below occur only on frame_tick, except start handling.
- start_edge = start_in high this cycle and low the previous cycle.
- Collision counter: 16-bit, saturating.
  - Increments on cycles with is_collision_in=1, hcount_in<ACTIVE_H_PIXELS, vcount_in<ACTIVE_LINES, state=APPROACH and win=1.
  - Cleared on every frame_tick, after being used for that tick's decision.
- win flag: latched on each frame_tick from current wall_depth and player_depth_in, using 9-bit unsigned compare.
  - win = (wall_depth <= player_depth+GOAL_DEPTH_DELTA) && (wall_depth+GOAL_DEPTH_DELTA >= player_depth).
- IDLE: on start_edge -> APPROACH.
  - Same cycle: lives=NUM_LIVES, score=0, wall_index=0, wall_depth=MAX_WALL_DEPTH, step counter=0, collision counter=0, win=0.
- APPROACH, priority on frame_tick:
  - (1) win was 1 for the finished frame and count>=COLLISION_THRESHOLD: lives-=1, last_pass=0, -> RESULT.
  - (2) wall_depth==0: score+=1 (saturating), last_pass=1, -> RESULT.
  - (3) otherwise step counter+=1; when it reaches FRAMES_PER_STEP it clears and wall_depth-=1.
  - A hit outranks reaching depth 0 on the same tick.
  - start_in is ignored.
- RESULT: wall_depth frozen; frame counter counts RESULT_FRAMES ticks, then:
  - If lives==0: -> GAME_OVER.
  - Otherwise: wall_index = (wall_index+1) mod NUM_WALLS, wall_depth=MAX_WALL_DEPTH, counters cleared, -> APPROACH.
- GAME_OVER: all outputs hold; start_edge -> IDLE.
  - Score and lives stay visible until the next start from IDLE.
- Outputs are registered; latency from frame_tick to the updated output is 1 cycle.
- wall_depth never underflows, because it only decrements while >0.
- Reset asserted mid-game returns to IDLE asynchronously; no partial state survives.

Test Plan:
- Setup: small raster (ACTIVE_H_PIXELS=8, ACTIVE_LINES=4), MAX_WALL_DEPTH=5, FRAMES_PER_STEP=1, RESULT_FRAMES=2, COLLISION_THRESHOLD=3, NUM_LIVES=2, NUM_WALLS=2.
- Reset: rst_in=0 mid-raster -> state=1, depth=5, lives=2, score=0, all outputs immediately.
- Clean pass: start pulse, no collisions -> depth 5,4,3,2,1,0 on successive frame_ticks; next tick state=3, score=1, last_pass=1; after 2 ticks state=2, depth=5, wall_index=1.
- Hit: player_depth=3, 3 collision pixels in active area during the frame after depth reaches 3 -> next tick lives=1, last_pass=0, state=3, score unchanged.
- Below threshold or outside window: 2 collision pixels in-window, or 10 collision pixels in blanking or with player_depth=40 -> no hit, depth keeps decrementing.
- Game over: second hit -> lives=0, RESULT for 2 ticks -> state=0; start_in held high (no edge) -> stays 0; new edge -> state=1; next edge -> state=2, lives=2, score=0.
- Wrap and saturation: 2 passes -> wall_index wraps 1->0; score preloaded to 255 plus a pass -> stays 255; hit and depth==0 on the same tick -> hit taken.

Source files
------------

// File: rtl/game_state_controller.sv
// Top-level hole-in-the-wall sequencer: game state, wall depth/selection, lives and score.
// Advances once per video frame, using the hcount/vcount raster as its timebase.
module game_state_controller #(
    parameter int unsigned ACTIVE_H_PIXELS     = 1280,
    parameter int unsigned ACTIVE_LINES        = 720,
    parameter int unsigned MAX_WALL_DEPTH      = 75,
    parameter int unsigned GOAL_DEPTH_DELTA    = 10,
    parameter int unsigned FRAMES_PER_STEP     = 2,
    parameter int unsigned COLLISION_THRESHOLD = 64,
    parameter int unsigned RESULT_FRAMES       = 90,
    parameter int unsigned NUM_LIVES           = 3,
    parameter int unsigned NUM_WALLS           = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        start_in,
    input  logic        is_collision_in,
    input  logic [7:0]  player_depth_in,
    output logic [2:0]  game_state_out,
    output logic [7:0]  wall_depth_out,
    output logic [3:0]  wall_index_out,
    output logic [1:0]  lives_out,
    output logic [7:0]  score_out,
    output logic        last_pass_out
);

    typedef enum logic [2:0] {
        StGameOver = 3'd0,
        StIdle     = 3'd1,
        StApproach = 3'd2,
        StResult   = 3'd3
    } state_e;

    localparam logic [10:0] HActive    = 11'(ACTIVE_H_PIXELS);
    localparam logic [9:0]  VActive    = 10'(ACTIVE_LINES);
    localparam logic [7:0]  MaxDepth   = 8'(MAX_WALL_DEPTH);
    localparam logic [8:0]  Delta      = 9'(GOAL_DEPTH_DELTA);
    localparam logic [15:0] StepLast   = 16'(FRAMES_PER_STEP - 1);
    localparam logic [15:0] Threshold  = 16'(COLLISION_THRESHOLD);
    localparam logic [15:0] ResultLast = 16'(RESULT_FRAMES - 1);
    localparam logic [1:0]  Lives      = 2'(NUM_LIVES);
    localparam logic [3:0]  WallLast   = 4'(NUM_WALLS - 1);

    state_e      state_q, state_d;
    logic [7:0]  depth_q, depth_d;
    logic [3:0]  index_q, index_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  score_q, score_d;
    logic        pass_q, pass_d;
    logic [15:0] coll_cnt_q, coll_cnt_d;
    logic [15:0] step_q, step_d;
    logic [15:0] frame_q, frame_d;
    logic        win_q, win_d;
    logic        tick_cond_q;
    logic        start_q;

    logic tick_cond;
    logic frame_tick;
    logic start_edge;
    logic count_pixel;
    logic win_now;
    logic hit;

    always_comb begin
        tick_cond   = (hcount_in == 11'd0) && (vcount_in == VActive);
        frame_tick  = tick_cond && !tick_cond_q;
        start_edge  = start_in && !start_q;
        count_pixel = is_collision_in && (hcount_in < HActive) && (vcount_in < VActive) &&
                      (state_q == StApproach) && win_q;
        // 9-bit compare so depth+delta cannot wrap
        win_now     = ({1'b0, depth_q} <= ({1'b0, player_depth_in} + Delta)) &&
                      (({1'b0, depth_q} + Delta) >= {1'b0, player_depth_in});
        hit         = win_q && (coll_cnt_q >= Threshold);
    end

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= StIdle;
            depth_q     <= MaxDepth;
            index_q     <= 4'd0;
            lives_q     <= Lives;
            score_q     <= 8'd0;
            pass_q      <= 1'b0;
            coll_cnt_q  <= 16'd0;
            step_q      <= 16'd0;
            frame_q     <= 16'd0;
            win_q       <= 1'b0;
            tick_cond_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            index_q     <= index_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            pass_q      <= pass_d;
            coll_cnt_q  <= coll_cnt_d;
            step_q      <= step_d;
            frame_q     <= frame_d;
            win_q       <= win_d;
            tick_cond_q <= tick_cond;
            start_q     <= start_in;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        index_d    = index_q;
        lives_d    = lives_q;
        score_d    = score_q;
        pass_d     = pass_q;
        coll_cnt_d = coll_cnt_q;
        step_d     = step_q;
        frame_d    = frame_q;
        win_d      = win_q;

        // The tick decision below reads the pre-tick count and win
        if (frame_tick) begin
            win_d      = win_now;
            coll_cnt_d = 16'd0;
        end else if (count_pixel && (coll_cnt_q != 16'hFFFF)) begin
            coll_cnt_d = coll_cnt_q + 16'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d    = StApproach;
                    lives_d    = Lives;
                    score_d    = 8'd0;
                    index_d    = 4'd0;
                    depth_d    = MaxDepth;
                    step_d     = 16'd0;
                    coll_cnt_d = 16'd0;
                    win_d      = 1'b0;
                end
            end
            StApproach: begin
                if (frame_tick) begin
                    if (hit) begin
                        if (lives_q != 2'd0) begin
                            lives_d = lives_q - 2'd1;
                        end
                        pass_d  = 1'b0;
                        frame_d = 16'd0;
                        state_d = StResult;
                    end else if (depth_q == 8'd0) begin
                        if (score_q != 8'hFF) begin
                            score_d = score_q + 8'd1;
                        end
                        pass_d  = 1'b1;
                        frame_d = 16'd0;
                        state_d = StResult;
                    end else if (step_q == StepLast) begin
                        step_d  = 16'd0;
                        depth_d = depth_q - 8'd1;
                    end else begin
                        step_d = step_q + 16'd1;
                    end
                end
            end
            StResult: begin
                if (frame_tick) begin
                    if (frame_q == ResultLast) begin
                        frame_d = 16'd0;
                        if (lives_q == 2'd0) begin
                            state_d = StGameOver;
                        end else begin
                            index_d    = (index_q == WallLast) ? 4'd0 : index_q + 4'd1;
                            depth_d    = MaxDepth;
                            step_d     = 16'd0;
                            coll_cnt_d = 16'd0;
                            state_d    = StApproach;
                        end
                    end else begin
                        frame_d = frame_q + 16'd1;
                    end
                end
            end
            StGameOver: begin
                if (start_edge) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        game_state_out = state_q;
        wall_depth_out = depth_q;
        wall_index_out = index_q;
        lives_out      = lives_q;
        score_out      = score_q;
        last_pass_out  = pass_q;
    end

endmodule

// File: tb/tb_game_state_controller.sv
// Self-checking bench: directed game scenarios plus randomized frames, compared each cycle
// against a frame-level behavioural model of the game rules.
module tb_game_state_controller;

    localparam int AH    = 8;
    localparam int AL    = 4;
    localparam int MAXD  = 5;
    localparam int DELTA = 10;
    localparam int FPS   = 1;
    localparam int THR   = 3;
    localparam int RF    = 2;
    localparam int NL    = 2;
    localparam int NW    = 2;

    localparam int GO   = 0;
    localparam int IDLE = 1;
    localparam int APP  = 2;
    localparam int RES  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        start = 1'b0;
    logic        coll = 1'b0;
    logic [7:0]  pd = '0;
    logic [2:0]  game_state;
    logic [7:0]  wall_depth;
    logic [3:0]  wall_index;
    logic [1:0]  lives;
    logic [7:0]  score;
    logic        last_pass;

    game_state_controller #(
        .ACTIVE_H_PIXELS    (AH),
        .ACTIVE_LINES       (AL),
        .MAX_WALL_DEPTH     (MAXD),
        .GOAL_DEPTH_DELTA   (DELTA),
        .FRAMES_PER_STEP    (FPS),
        .COLLISION_THRESHOLD(THR),
        .RESULT_FRAMES      (RF),
        .NUM_LIVES          (NL),
        .NUM_WALLS          (NW)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .hcount_in      (hcount),
        .vcount_in      (vcount),
        .start_in       (start),
        .is_collision_in(coll),
        .player_depth_in(pd),
        .game_state_out (game_state),
        .wall_depth_out (wall_depth),
        .wall_index_out (wall_index),
        .lives_out      (lives),
        .score_out      (score),
        .last_pass_out  (last_pass)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model of the game rules
    int ms, md, mi, ml, msc, mp, mc, mwin, mstep, mfr, mcond_prev, mstart_prev;

    task automatic model_reset();
        ms = IDLE; md = MAXD; mi = 0; ml = NL; msc = 0; mp = 0;
        mc = 0; mwin = 0; mstep = 0; mfr = 0; mcond_prev = 0; mstart_prev = 0;
    endtask

    task automatic model_step();
        int h, v, p, cond, tick, sedge, ncnt, nwin;
        h = int'(hcount); v = int'(vcount); p = int'(pd);
        cond  = (h == 0 && v == AL) ? 1 : 0;
        tick  = (cond == 1 && mcond_prev == 0) ? 1 : 0;
        sedge = (start == 1'b1 && mstart_prev == 0) ? 1 : 0;
        ncnt = mc;
        nwin = mwin;
        if (tick == 1) begin
            nwin = (md <= p + DELTA && md + DELTA >= p) ? 1 : 0;
            ncnt = 0;
        end else if (coll && h < AH && v < AL && ms == APP && mwin == 1 && mc < 65535) begin
            ncnt = mc + 1;
        end
        case (ms)
            IDLE: if (sedge == 1) begin
                ms = APP; ml = NL; msc = 0; mi = 0; md = MAXD; mstep = 0; ncnt = 0; nwin = 0;
            end
            APP: if (tick == 1) begin
                if (mwin == 1 && mc >= THR) begin
                    ml = ml - 1; mp = 0; ms = RES; mfr = 0;
                end else if (md == 0) begin
                    msc = (msc < 255) ? msc + 1 : 255; mp = 1; ms = RES; mfr = 0;
                end else begin
                    mstep++;
                    if (mstep == FPS) begin mstep = 0; md--; end
                end
            end
            RES: if (tick == 1) begin
                mfr++;
                if (mfr == RF) begin
                    mfr = 0;
                    if (ml == 0) ms = GO;
                    else begin
                        mi = (mi + 1) % NW; md = MAXD; mstep = 0; ncnt = 0; ms = APP;
                    end
                end
            end
            default: if (sedge == 1) ms = IDLE;
        endcase
        mc = ncnt;
        mwin = nwin;
        mcond_prev = cond;
        mstart_prev = start ? 1 : 0;
    endtask

    task automatic check_outputs();
        check_eq("state", 32'(game_state), 32'(ms));
        check_eq("depth", 32'(wall_depth), 32'(md));
        check_eq("index", 32'(wall_index), 32'(mi));
        check_eq("lives", 32'(lives), 32'(ml));
        check_eq("score", 32'(score), 32'(msc));
        check_eq("last_pass", 32'(last_pass), 32'(mp));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic px(input int h, input int v, input bit c);
        hcount = 11'(h);
        vcount = 10'(v);
        coll = c;
        cycle();
    endtask

    // Compressed frame: collision pixels inside and outside the active area, then the tick
    task automatic frame(input int n_in, input int n_blank);
        for (int k = 0; k < n_in; k++) px($urandom_range(AH - 1), $urandom_range(AL - 1), 1'b1);
        for (int k = 0; k < n_blank; k++) px(AH + $urandom_range(3), $urandom_range(AL + 1), 1'b1);
        px(3, 1, 1'b0);
        px(0, AL, 1'b0);
    endtask

    task automatic do_reset();
        hcount = 11'($urandom_range(AH - 1));
        vcount = 10'($urandom_range(AL - 1));
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        px(2, 1, 1'b0);
    endtask

    task automatic run_until_state(input int target, input string tag);
        int guard;
        guard = 0;
        while (ms != target && guard < 40) begin
            frame(0, 0);
            guard++;
        end
        if (guard >= 40) check_eq(tag, 32'(guard), 32'd0);
    endtask

    initial begin
        int guard;
        model_reset();
        @(negedge clk);
        do_reset();
        check_eq("reset_state", 32'(game_state), 32'd1);
        check_eq("reset_depth", 32'(wall_depth), 32'd5);

        // Clean pass
        pd = 8'd40;
        start = 1'b1;
        px(3, 1, 1'b0);
        start = 1'b0;
        check_eq("start_state", 32'(game_state), 32'd2);
        for (int d = 4; d >= 0; d--) begin
            frame(0, 0);
            check_eq("clean_depth", 32'(wall_depth), 32'(d));
        end
        frame(0, 0);
        check_eq("clean_result", 32'(game_state), 32'd3);
        check_eq("clean_score", 32'(score), 32'd1);
        check_eq("clean_pass", 32'(last_pass), 32'd1);
        frame(0, 0);
        frame(0, 0);
        check_eq("next_wall_state", 32'(game_state), 32'd2);
        check_eq("next_wall_index", 32'(wall_index), 32'd1);
        check_eq("next_wall_depth", 32'(wall_depth), 32'd5);

        // Hit at depth 3
        pd = 8'd3;
        frame(0, 0);
        frame(0, 0);
        frame(3, 0);
        check_eq("hit_lives", 32'(lives), 32'd1);
        check_eq("hit_state", 32'(game_state), 32'd3);
        check_eq("hit_pass", 32'(last_pass), 32'd0);
        check_eq("hit_score", 32'(score), 32'd1);
        frame(0, 0);
        frame(0, 0);
        check_eq("wrap_index", 32'(wall_index), 32'd0);

        // Below threshold, blanking collisions, out-of-window player
        frame(2, 0);
        frame(0, 10);
        pd = 8'd40;
        frame(0, 0);
        frame(10, 0);
        check_eq("no_hit_state", 32'(game_state), 32'd2);
        check_eq("no_hit_lives", 32'(lives), 32'd1);
        run_until_state(RES, "bound_pass");
        run_until_state(APP, "bound_next");

        // Game over, start held high across it
        start = 1'b1;
        pd = 8'd3;
        frame(0, 0);
        frame(4, 0);
        check_eq("go_lives", 32'(lives), 32'd0);
        frame(0, 0);
        frame(0, 0);
        check_eq("go_state", 32'(game_state), 32'd0);
        frame(0, 0);
        check_eq("go_hold", 32'(game_state), 32'd0);
        start = 1'b0;
        px(2, 2, 1'b0);
        start = 1'b1;
        px(2, 2, 1'b0);
        check_eq("go_idle", 32'(game_state), 32'd1);
        check_eq("go_idle_lives", 32'(lives), 32'd0);
        start = 1'b0;
        px(2, 2, 1'b0);
        start = 1'b1;
        px(2, 2, 1'b0);
        start = 1'b0;
        check_eq("restart_state", 32'(game_state), 32'd2);
        check_eq("restart_lives", 32'(lives), 32'd2);
        check_eq("restart_score", 32'(score), 32'd0);

        // Score saturation
        pd = 8'd40;
        guard = 0;
        while (msc < 255 && guard < 4000) begin
            frame(0, 0);
            guard++;
        end
        if (guard >= 4000) check_eq("bound_sat", 32'(guard), 32'd0);
        run_until_state(APP, "bound_sat_app");
        run_until_state(RES, "bound_sat_res");
        check_eq("score_sat", 32'(score), 32'd255);

        // Hit and depth 0 on the same tick
        run_until_state(APP, "bound_same_app");
        pd = 8'd0;
        guard = 0;
        while (md != 0 && guard < 40) begin
            frame(0, 0);
            guard++;
        end
        if (guard >= 40) check_eq("bound_same", 32'(guard), 32'd0);
        frame(3, 0);
        check_eq("same_tick_pass", 32'(last_pass), 32'd0);
        check_eq("same_tick_lives", 32'(lives), 32'd1);
        check_eq("same_tick_score", 32'(score), 32'd255);

        // Randomized play
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(7) == 0) start = ~start;
            pd = ($urandom_range(3) == 0) ? 8'(40 + $urandom_range(200)) : 8'($urandom_range(12));
            if ($urandom_range(99) == 0) do_reset();
            frame($urandom_range(5), $urandom_range(3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
